// File: rtl/alu_exec_unit.sv
// Execution-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ADD/SUB/AND/COMPARE; LEFT_SHIFT iterates one bit per cycle.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALU_Control,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Result,
    output logic             Zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_AND     = 3'b010;
    localparam logic [2:0] OP_SHL     = 3'b011;
    localparam logic [2:0] OP_COMPARE = 3'b100;

    state_t               state, stateNext;
    logic [WIDTH-1:0]     result, resultNext;
    logic [SHAMT_W-1:0]   count, countNext;
    logic                 zeroFlag;
    logic [SHAMT_W-1:0]   shamt;
    logic                 lessThan;

    assign shamt    = SrcB[SHAMT_W-1:0];
    assign lessThan = $signed(SrcA) < $signed(SrcB);

    // The result register doubles as the shift working register; it is only
    // presented as valid in DONE, so intermediate shift values are harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            result   <= '0;
            count    <= '0;
            zeroFlag <= 1'b1;
        end else begin
            state    <= stateNext;
            result   <= resultNext;
            count    <= countNext;
            zeroFlag <= (resultNext == '0);
        end
    end

    always_comb begin
        stateNext  = state;
        resultNext = result;
        countNext  = count;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    stateNext = DONE;
                    case (ALU_Control)
                        OP_SUB:     resultNext = SrcA - SrcB;
                        OP_AND:     resultNext = SrcA & SrcB;
                        OP_COMPARE: resultNext = {{(WIDTH-1){1'b0}}, lessThan};
                        OP_SHL: begin
                            resultNext = SrcA;
                            countNext  = shamt;
                            if (shamt != '0) begin
                                stateNext = SHIFT;
                            end
                        end
                        // ADD and the unused codes 101/110/111
                        default:    resultNext = SrcA + SrcB;
                    endcase
                end
            end
            SHIFT: begin
                resultNext = {result[WIDTH-2:0], 1'b0};
                countNext  = count - SHAMT_W'(1);
                if (count == SHAMT_W'(1)) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign ALU_Result = result;
    assign Zero       = zeroFlag;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: arithmetic results, shift
// latency, backpressure, mid-operation reset and operand capture.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [2:0]  aluControl;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        outValid;
    logic        outReady;
    logic [31:0] aluResult;
    logic        zero;

    int compared;
    int mismatched;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .ALU_Control(aluControl),
        .SrcA       (srcA),
        .SrcB       (srcB),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .ALU_Result (aluResult),
        .Zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one operation, measure accept-to-out_valid latency, check the
    // result, then complete the output handshake.
    task automatic applyStimulus(input string tag, input logic [2:0] ctrl,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expRes, input int expLat);
        int lat;
        checkOutput({tag, "_rdy_before"}, 32'(inReady), 32'd1);
        aluControl = ctrl;
        srcA       = a;
        srcB       = b;
        inValid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        srcA    = ~a;
        srcB    = ~b;
        lat     = 1;
        while (!outValid && lat < 40) begin
            checkOutput({tag, "_rdy_busy"}, 32'(inReady), 32'd0);
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_valid"}, 32'(outValid), 32'd1);
        checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
        checkOutput({tag, "_res"}, aluResult, expRes);
        checkOutput({tag, "_zero"}, 32'(zero), 32'(expRes == 32'd0));
        checkOutput({tag, "_rdy_done"}, 32'(inReady), 32'd0);
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        checkOutput({tag, "_valid_after"}, 32'(outValid), 32'd0);
        checkOutput({tag, "_rdy_after"}, 32'(inReady), 32'd1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_rdy"}, 32'(inReady), 32'd1);
        checkOutput({tag, "_valid"}, 32'(outValid), 32'd0);
        checkOutput({tag, "_res"}, aluResult, 32'd0);
        checkOutput({tag, "_zero"}, 32'(zero), 32'd1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        inValid    = 1'b0;
        outReady   = 1'b0;
        aluControl = 3'b000;
        srcA       = '0;
        srcB       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkResetState("reset");

        applyStimulus("add",      3'b000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1);
        applyStimulus("add_ovf",  3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
        applyStimulus("sub_eq",   3'b001, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1);
        applyStimulus("sub",      3'b001, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1);
        applyStimulus("cmp_lt",   3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
        applyStimulus("cmp_ge",   3'b100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        applyStimulus("shl4",     3'b011, 32'h0000_0001, 32'h0000_0004, 32'h0000_0010, 5);
        applyStimulus("shl0",     3'b011, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1);
        applyStimulus("shl31",    3'b011, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 32);
        applyStimulus("shl_hi",   3'b011, 32'h0000_0003, 32'hFFFF_FF22, 32'h0000_000C, 3);
        applyStimulus("op101",    3'b101, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1);
        applyStimulus("op110",    3'b110, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1);
        applyStimulus("op111",    3'b111, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1);

        // Backpressure: result must hold while new requests are ignored
        aluControl = 3'b010;
        srcA       = 32'hF0F0_F0F0;
        srcB       = 32'h0FF0_0FF0;
        inValid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        aluControl = 3'b000;
        srcA       = 32'h0000_0001;
        srcB       = 32'h0000_0001;
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_valid", 32'(outValid), 32'd1);
            checkOutput("bp_res", aluResult, 32'h00F0_00F0);
            checkOutput("bp_rdy", 32'(inReady), 32'd0);
            @(negedge clk);
        end
        outReady = 1'b1;
        @(negedge clk);
        inValid  = 1'b0;
        outReady = 1'b0;
        checkOutput("bp_rdy_after", 32'(inReady), 32'd1);
        checkOutput("bp_valid_after", 32'(outValid), 32'd0);
        checkOutput("bp_res_hold", aluResult, 32'h00F0_00F0);

        // out_ready held high early: result is shown for exactly one cycle
        outReady   = 1'b1;
        aluControl = 3'b000;
        srcA       = 32'h0000_0100;
        srcB       = 32'h0000_0023;
        inValid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        checkOutput("early_valid", 32'(outValid), 32'd1);
        checkOutput("early_res", aluResult, 32'h0000_0123);
        @(negedge clk);
        outReady = 1'b0;
        checkOutput("early_valid_after", 32'(outValid), 32'd0);
        checkOutput("early_rdy_after", 32'(inReady), 32'd1);

        // Reset in the middle of a long shift
        aluControl = 3'b011;
        srcA       = 32'h0000_0001;
        srcB       = 32'h0000_0014;
        inValid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("midrst_busy", 32'(inReady), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkResetState("midrst");
        applyStimulus("post_rst_add", 3'b000, 32'h0000_000A, 32'h0000_0014, 32'h0000_001E, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-stage ALU that consumes the 3-bit ALU_Control code produced by the ALU control decoder.
- Operates on two registered operands and returns a result plus a Zero flag over valid/ready handshakes.
- ADD, SUB, AND and COMPARE complete in one cycle. LEFT_SHIFT runs iteratively, one bit per cycle, so no barrel shifter is needed.
- Sits between operand select (upstream) and writeback/branch logic (downstream).

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHAMT_W, 5, shift-amount width; shift amount is SrcB[SHAMT_W-1:0].

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents an operation.
- in_ready  out  1  unit can accept an operation.
- ALU_Control  in  3  operation code: 000 ADD, 001 SUB, 010 AND, 011 LEFT_SHIFT, 100 COMPARE; 101/110/111 execute as ADD.
- SrcA  in  WIDTH  operand A.
- SrcB  in  WIDTH  operand B; low SHAMT_W bits are the shift amount for LEFT_SHIFT.
- out_valid  out  1  ALU_Result/Zero are valid.
- out_ready  in  1  downstream accepts the result.
- ALU_Result  out  WIDTH  operation result.
- Zero  out  1  high when ALU_Result == 0.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE, in_ready=1, out_valid=0, ALU_Result=0, Zero=1, shift counter=0.
  - Takes priority over everything; aborts any in-flight op, including mid-shift or a held result.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE), combinational from state. No acceptance in SHIFT or DONE.
- Accept occurs when in_valid & in_ready at a clock edge. ALU_Control, SrcA and SrcB are captured into internal registers; later input changes are ignored.
- IDLE on accept:
  - ADD: result = SrcA + SrcB, mod 2^WIDTH, carry discarded.
  - SUB: result = SrcA - SrcB, mod 2^WIDTH.
  - AND: result = SrcA & SrcB.
  - COMPARE: result = {WIDTH-1 zeros, ($signed(SrcA) < $signed(SrcB))}.
  - Codes 101/110/111: result as ADD.
  - For all of the above the result is registered and the next state is DONE: out_valid rises the cycle after accept (latency 1).
  - LEFT_SHIFT:
    - Load working register = SrcA, counter = SrcB[SHAMT_W-1:0].
    - If counter==0, go straight to DONE with result = SrcA (latency 1).
    - Otherwise go to SHIFT.
- SHIFT, each cycle:
  - working <<= 1 (zero fill); counter -= 1.
  - When the counter reaches 0 on this cycle, go to DONE with the final value.
  - Total latency from accept to out_valid = shamt + 1 cycles; shamt=31 gives 32 cycles.
  - SrcB bits above SHAMT_W are ignored.
- DONE:
  - out_valid=1; ALU_Result and Zero held stable until out_valid & out_ready at a clock edge, then IDLE.
  - out_ready may be held high early; no combinational path from out_ready to out_valid.
  - Throughput for single-cycle ops is 1 op per 2 cycles.
- Zero is registered with ALU_Result and is always consistent with it, including after reset (0 → Zero=1).
- ALU_Result is not cleared on handshake; it holds its last value in IDLE. Consumers must qualify it with out_valid.

Test Plan:
- Reset then ADD: SrcA=0x0000_0005, SrcB=0x0000_0003, ctrl=000 → out_valid next cycle, ALU_Result=0x0000_0008, Zero=0. Overflow case 0xFFFF_FFFF + 1 → 0x0000_0000, Zero=1.
- SUB and COMPARE:
  - SUB 7-7 → 0, Zero=1.
  - COMPARE SrcA=0xFFFF_FFFF (-1), SrcB=1 → ALU_Result=1.
  - COMPARE SrcA=1, SrcB=0xFFFF_FFFF → 0.
- LEFT_SHIFT latency:
  - SrcA=0x0000_0001, SrcB=0x0000_0004 → out_valid exactly 5 cycles after accept, result 0x0000_0010.
  - SrcB=0 → 1 cycle, result=SrcA.
  - SrcB=0x0000_003F (shamt=31) → 32 cycles, result 0x8000_0000.
  - Check in_ready=0 throughout SHIFT/DONE.
- Backpressure: AND 0xF0F0_F0F0 & 0x0FF0_0FF0 with out_ready=0 for 10 cycles → out_valid stays 1, ALU_Result=0x00F0_00F0 stable, in_valid ignored. Raise out_ready → IDLE next cycle, in_ready=1.
- Reset mid-operation: start LEFT_SHIFT shamt=20, assert rst on cycle 6 → next cycle state IDLE, out_valid=0, ALU_Result=0, Zero=1. A new ADD then completes normally.
- Unused codes 101/110/111 with SrcA=2, SrcB=3 → ALU_Result=5. Input change after accept (SrcA toggled) → result unaffected.
